single_argmax_v: RTL and testbench



---
 rtl/single_argmax_v.sv | 132 +++++++++++++
 tb/tb_single_argmax_v.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/single_argmax_v.sv
// Sequential arg-max over a captured WIDTH-element IEEE-754 single vector.
// It compares one element per clock and reports the index and value of the largest element.
module single_argmax_v #(
  parameter int WIDTH   = 10,
  parameter int INDEX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic [31:0]        vector_a [WIDTH],
  output logic               in_ready,
  output logic               out_valid,
  output logic [INDEX_W-1:0] out_index,
  output logic [31:0]        out_value
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(WIDTH - 1);

  // Map a float onto an unsigned key.
  // Negative floats are inverted so that plain unsigned compare gives the total order.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] ptr_q, ptr_d;
  logic [INDEX_W-1:0] best_idx_q, best_idx_d;
  logic [31:0]        best_val_q, best_val_d;
  logic               best_nan_q, best_nan_d;
  logic               out_valid_q, out_valid_d;
  logic [INDEX_W-1:0] out_index_q, out_index_d;
  logic [31:0]        out_value_q, out_value_d;
  logic [31:0]        buf_q [WIDTH];
  logic               capture;
  logic [31:0]        cand;
  logic               cand_wins;

  // While reset is held, the block is not ready, even though the state is IDLE.
  assign in_ready  = rstn && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_value = out_value_q;

  always_comb begin
    cand = 32'h0000_0000;
    for (int i = 0; i < WIDTH; i++) begin
      if (ptr_q == INDEX_W'(i)) cand = buf_q[i];
    end
  end

  // A NaN best value is held only while every element seen so far is NaN.
  // The first non-NaN element then replaces it, whatever its value.
  assign cand_wins = !is_nan(cand) &&
                     (best_nan_q || (order_key(cand) > order_key(best_val_q)));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    best_idx_d  = best_idx_q;
    best_val_d  = best_val_q;
    best_nan_d  = best_nan_q;
    out_valid_d = 1'b0;
    out_index_d = out_index_q;
    out_value_d = out_value_q;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          capture    = 1'b1;
          best_idx_d = '0;
          best_val_d = vector_a[0];
          best_nan_d = is_nan(vector_a[0]);
          ptr_d      = INDEX_W'(1);
          state_d    = (WIDTH > 1) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (cand_wins) begin
          best_idx_d = ptr_q;
          best_val_d = cand;
          best_nan_d = 1'b0;
        end
        if (ptr_q == LAST_IDX) state_d = DONE;
        else                   ptr_d   = ptr_q + INDEX_W'(1);
      end
      DONE: begin
        out_valid_d = 1'b1;
        out_index_d = best_idx_q;
        out_value_d = best_val_q;
        ptr_d       = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      best_idx_q  <= '0;
      best_val_q  <= 32'h0000_0000;
      best_nan_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_value_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      best_idx_q  <= best_idx_d;
      best_val_q  <= best_val_d;
      best_nan_q  <= best_nan_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_value_q <= out_value_d;
    end
  end

  // The vector buffer carries no reset, because it is always written before it is read.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < WIDTH; i++) buf_q[i] <= vector_a[i];
    end
  end

endmodule

// File: tb/tb_single_argmax_v.sv
// Directed bench for single_argmax_v.
// One instance uses WIDTH=10 and a second instance checks the WIDTH=1 case.
module tb_single_argmax_v;

  typedef logic [31:0] vec_t [10];

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  vec_t        vec_a;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_index;
  logic [31:0] out_value;

  logic        in_valid1 = 1'b0;
  logic [31:0] vec1 [1];
  logic        in_ready1;
  logic        out_valid1;
  logic [0:0]  out_index1;
  logic [31:0] out_value1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  single_argmax_v #(.WIDTH(10)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .vector_a(vec_a),
    .in_ready(in_ready), .out_valid(out_valid), .out_index(out_index), .out_value(out_value)
  );

  single_argmax_v #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid1), .vector_a(vec1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_index(out_index1), .out_value(out_value1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int exp_idx, input logic [31:0] exp_val);
    int guard;
    int lat;
    int ready_hi;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    vec_a    = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    ready_hi = 0;
    while (!out_valid && lat < 30) begin
      ready_hi += int'(in_ready);
      tick();
      lat++;
    end
    $display("vec %s: index=%0d value=%h latency=%0d", tag, out_index, out_value, lat);
    check({tag, "_lat"}, 32'(lat), 32'd10);
    check({tag, "_busy"}, 32'(ready_hi), 32'd0);
    check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    check({tag, "_idx"}, 32'(out_index), 32'(exp_idx));
    check({tag, "_val"}, out_value, exp_val);
    tick();
    check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    check({tag, "_hold"}, out_value, exp_val);
  endtask

  initial begin
    vec_t v;
    int   pulses;
    int   k;
    for (int i = 0; i < 10; i++) vec_a[i] = 32'h0;
    vec1[0] = 32'h0;

    // Reset and idle
    #2;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    #1;
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_idx", 32'(out_index), 32'd0);
    check("idle_val", out_value, 32'h0);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      pulses += int'(out_valid);
    end
    check("idle_nopulse", 32'(pulses), 32'd0);
    $display("vec reset_idle: pulses=%0d", pulses);

    v = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3F666666, 32'h3E99999A, 32'h3ECCCCCD,
          32'h3F000000, 32'h3F19999A, 32'h3F333333, 32'h3F4CCCCD, 32'h3DCCCCCD};
    run_vec("basic", v, 2, 32'h3F666666);

    v = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3F666666, 32'h3E99999A, 32'h3ECCCCCD,
          32'h3F000000, 32'h3F19999A, 32'h3F333333, 32'h3F4CCCCD, 32'h3F800000};
    run_vec("last", v, 9, 32'h3F800000);

    for (int i = 0; i < 10; i++) v[i] = 32'h3F000000;
    run_vec("tie_all", v, 0, 32'h3F000000);

    v = '{32'h3DCCCCCD, 32'h3F666666, 32'h3F000000, 32'h3F666666, 32'h3E000000,
          32'h3E000000, 32'h3E000000, 32'h3E000000, 32'h3E000000, 32'h3E000000};
    run_vec("tie_mid", v, 1, 32'h3F666666);

    v = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
          32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000};
    run_vec("signed_zero", v, 1, 32'h00000000);

    v = '{32'h7FC00000, 32'hBF800000, 32'hFF800000, 32'h3F800000, 32'hFF800000,
          32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000};
    run_vec("special", v, 3, 32'h3F800000);

    v = '{32'h7FC00000, 32'hFF800000, 32'hFFC00001, 32'hFF800000, 32'hFF800000,
          32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hFF800000};
    run_vec("nan_then_minf", v, 1, 32'hFF800000);

    v = '{32'h3F800000, 32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h7F800001,
          32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    run_vec("pinf_nan", v, 1, 32'h7F800000);

    v = '{32'h7FC00000, 32'hFFC00001, 32'h7F800001, 32'hFFC00001, 32'hFFC00001,
          32'hFFC00001, 32'hFFC00001, 32'hFFC00001, 32'hFFC00001, 32'hFFC00001};
    run_vec("all_nan", v, 0, 32'h7FC00000);

    v = '{32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000, 32'hC0400000,
          32'hC0400000, 32'hC0400000, 32'hC0400000, 32'hC0400000, 32'hC0400000};
    run_vec("negatives", v, 2, 32'hBF000000);

    // Back-to-back: the vector changes every cycle and captures land at cycles 0, 11 and 22
    pulses   = 0;
    in_valid = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      for (int i = 0; i < 10; i++)
        vec_a[i] = (i == c % 10) ? 32'h3F000000 + 32'(c) : 32'h3E000000;
      tick();
      if (out_valid) begin
        k = pulses;
        check("b2b_edge", 32'(c), 32'(10 + 11 * k));
        check("b2b_idx", 32'(out_index), 32'((11 * k) % 10));
        check("b2b_val", out_value, 32'h3F000000 + 32'(11 * k));
        $display("vec b2b_%0d: index=%0d value=%h edge=%0d", k, out_index, out_value, c);
        pulses++;
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(pulses), 32'd3);
    tick();

    // WIDTH=1 instance
    vec1[0]   = 32'h40490FDB;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("w1_busy", 32'(in_ready1), 32'd0);
    check("w1_early", 32'(out_valid1), 32'd0);
    tick();
    check("w1_valid", 32'(out_valid1), 32'd1);
    check("w1_idx", 32'(out_index1), 32'd0);
    check("w1_val", out_value1, 32'h40490FDB);
    check("w1_ready", 32'(in_ready1), 32'd1);
    $display("vec width1: index=%0d value=%h", out_index1, out_value1);
    tick();
    check("w1_pulse", 32'(out_valid1), 32'd0);

    // Reset during a scan
    for (int i = 0; i < 10; i++) vec_a[i] = (i == 5) ? 32'h3F7FFFFF : 32'h3E000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("mid_rst_idx", 32'(out_index), 32'd0);
    check("mid_rst_val", out_value, 32'h0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_w1val", out_value1, 32'h0);
    pulses = 0;
    tick();
    pulses += int'(out_valid);
    tick();
    pulses += int'(out_valid);
    rstn = 1'b1;
    #1;
    check("rel_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 15; c++) begin
      tick();
      pulses += int'(out_valid);
    end
    check("mid_rst_nopulse", 32'(pulses), 32'd0);
    $display("vec reset_mid_scan: pulses=%0d", pulses);

    v = '{32'h3E000000, 32'h3E000000, 32'h3E000000, 32'h3E000000, 32'h3E000000,
          32'h3E000000, 32'h3E000000, 32'h3F400000, 32'h3E000000, 32'h3E000000};
    run_vec("after_rst", v, 7, 32'h3F400000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
